// File: rtl/sha2_xl_feeder.sv
// Sequencer for the sha2_xl core: loads the message length, packs input words into
// 16-word blocks, runs each block and reads the digest back as one wide word.
module sha2_xl_feeder #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MAX_H      = 8,
    parameter int unsigned BLOCK_SIZE = 16 * WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     msg_start,
    input  logic [2*WIDTH-1:0]       msg_len,
    output logic                     busy,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [3:0]               core_control,
    output logic [4:0]               core_ad_in,
    output logic [WIDTH-1:0]         core_data_in,
    output logic [4:0]               core_ad_out,
    input  logic [WIDTH-1:0]         core_data_out,
    input  logic                     core_end_op,
    output logic [MAX_H*WIDTH-1:0]   dig_out,
    output logic                     dig_valid
);

    localparam int unsigned LW = 2 * WIDTH;
    localparam int unsigned SW = $clog2(WIDTH);
    localparam int unsigned BW = $clog2(BLOCK_SIZE);
    localparam int unsigned RW = $clog2(MAX_H + 1);

    localparam logic [3:0] C_IDLE  = 4'b0000;
    localparam logic [3:0] C_RST   = 4'b0001;
    localparam logic [3:0] C_LEN   = 4'b1000;
    localparam logic [3:0] C_LOAD  = 4'b0010;
    localparam logic [3:0] C_START = 4'b0100;

    typedef enum logic [2:0] {
        S_IDLE, S_CRST, S_LEN, S_LOAD_A, S_LOAD_D, S_START, S_READ, S_DONE
    } state_t;

    state_t                  state, state_n;
    logic [LW-1:0]           len_q, n_words, n_block, consumed, consumed_n, blk, blk_n;
    logic [SW-1:0]           rem_q;
    logic [2:0]              cnt, cnt_n;
    logic [3:0]              widx, widx_n;
    logic [RW-1:0]           rd_idx, rd_n;
    logic [3:0]              ctrl_n;
    logic [4:0]              ad_in_n, ad_out_n;
    logic [WIDTH-1:0]        data_in_n;
    logic                    in_ready_n, busy_n, dig_valid_n;
    logic [MAX_H*WIDTH-1:0]  dig_n;

    logic                    take_c, words_left_c, last_c;
    logic [LW:0]             words_sum_c, blk_sum_c;
    logic [LW-1:0]           blk_inc_c;
    logic [WIDTH-1:0]        ones_c, word_c;
    logic [31:0]             dig_sel_c;

    // Length-derived counts, sized one bit wider so the additions cannot overflow
    assign take_c       = (state == S_IDLE) && msg_start;
    assign words_sum_c  = {1'b0, msg_len} + (LW+1)'(WIDTH - 1);
    assign blk_sum_c    = {1'b0, msg_len} + (LW+1)'(2 * WIDTH);
    assign words_left_c = consumed < n_words;
    assign last_c       = consumed == (n_words - LW'(1));
    assign blk_inc_c    = blk + LW'(1);
    assign ones_c       = '1;
    assign word_c       = (last_c && (rem_q != '0)) ? (in_data & ~(ones_c >> rem_q)) : in_data;
    assign dig_sel_c    = 32'(MAX_H - 1) - 32'(rd_idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q   <= '0;
            n_words <= '0;
            n_block <= '0;
            rem_q   <= '0;
        end else if (take_c) begin
            len_q   <= msg_len;
            n_words <= LW'(words_sum_c >> SW);
            n_block <= LW'(blk_sum_c >> BW) + LW'(1);
            rem_q   <= msg_len[SW-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            core_control <= '0;
            core_ad_in   <= '0;
            core_data_in <= '0;
            core_ad_out  <= '0;
            in_ready     <= 1'b0;
            busy         <= 1'b0;
            dig_valid    <= 1'b0;
            dig_out      <= '0;
            cnt          <= '0;
            widx         <= '0;
            blk          <= '0;
            consumed     <= '0;
            rd_idx       <= '0;
        end else begin
            state        <= state_n;
            core_control <= ctrl_n;
            core_ad_in   <= ad_in_n;
            core_data_in <= data_in_n;
            core_ad_out  <= ad_out_n;
            in_ready     <= in_ready_n;
            busy         <= busy_n;
            dig_valid    <= dig_valid_n;
            dig_out      <= dig_n;
            cnt          <= cnt_n;
            widx         <= widx_n;
            blk          <= blk_n;
            consumed     <= consumed_n;
            rd_idx       <= rd_n;
        end
    end

    // Outputs are computed for the state being entered, so they line up with it
    always_comb begin
        state_n     = state;
        ctrl_n      = core_control;
        ad_in_n     = core_ad_in;
        data_in_n   = core_data_in;
        ad_out_n    = core_ad_out;
        in_ready_n  = 1'b0;
        busy_n      = busy;
        dig_valid_n = 1'b0;
        dig_n       = dig_out;
        cnt_n       = cnt;
        widx_n      = widx;
        blk_n       = blk;
        consumed_n  = consumed;
        rd_n        = rd_idx;
        case (state)
            S_IDLE: begin
                ctrl_n = C_IDLE;
                if (msg_start) begin
                    state_n    = S_CRST;
                    ctrl_n     = C_RST;
                    busy_n     = 1'b1;
                    cnt_n      = '0;
                    consumed_n = '0;
                    blk_n      = '0;
                end
            end
            S_CRST: begin
                if (cnt == 3'd1) begin
                    state_n = S_LEN;
                    ctrl_n  = C_LEN;
                    ad_in_n = '0;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 3'd1;
                end
            end
            S_LEN: begin
                cnt_n = cnt + 3'd1;
                case (cnt)
                    3'd0: data_in_n = len_q[LW-1:WIDTH];
                    3'd1: ad_in_n = 5'd1;
                    3'd2: data_in_n = len_q[WIDTH-1:0];
                    3'd4: begin
                        state_n    = S_LOAD_A;
                        ctrl_n     = C_LOAD;
                        ad_in_n    = '0;
                        widx_n     = '0;
                        blk_n      = '0;
                        cnt_n      = '0;
                        in_ready_n = words_left_c;
                    end
                    default: ;
                endcase
            end
            S_LOAD_A: begin
                if (words_left_c) begin
                    if (in_valid) begin
                        data_in_n  = word_c;
                        consumed_n = consumed + LW'(1);
                        state_n    = S_LOAD_D;
                    end else begin
                        in_ready_n = 1'b1;
                    end
                end else begin
                    data_in_n = '0;
                    state_n   = S_LOAD_D;
                end
            end
            S_LOAD_D: begin
                if (widx == 4'd15) begin
                    state_n = S_START;
                    ctrl_n  = C_START;
                end else begin
                    widx_n     = widx + 4'd1;
                    ad_in_n    = {1'b0, widx + 4'd1};
                    state_n    = S_LOAD_A;
                    in_ready_n = words_left_c;
                end
            end
            S_START: begin
                if (core_end_op) begin
                    blk_n = blk_inc_c;
                    if (blk_inc_c < n_block) begin
                        state_n    = S_LOAD_A;
                        ctrl_n     = C_LOAD;
                        widx_n     = '0;
                        ad_in_n    = '0;
                        in_ready_n = words_left_c;
                    end else begin
                        state_n  = S_READ;
                        ctrl_n   = C_IDLE;
                        ad_out_n = '0;
                        rd_n     = '0;
                        cnt_n    = '0;
                    end
                end
            end
            S_READ: begin
                // Address in one cycle, capture the read data in the next
                if (cnt == 3'd0) begin
                    cnt_n = 3'd1;
                end else begin
                    dig_n[dig_sel_c*WIDTH +: WIDTH] = core_data_out;
                    cnt_n = '0;
                    if (rd_idx == RW'(MAX_H - 1)) begin
                        state_n     = S_DONE;
                        dig_valid_n = 1'b1;
                        busy_n      = 1'b0;
                        ctrl_n      = C_IDLE;
                    end else begin
                        rd_n     = rd_idx + RW'(1);
                        ad_out_n = 5'(rd_idx + RW'(1));
                    end
                end
            end
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: doc/sha2_xl_feeder.md
Name: sha2_xl_feeder

Overview:
- Upstream sequencer for the sha2_xl core.
- Accepts a message length plus a stream of left-aligned message words (valid/ready).
- Packs the words into 16-word blocks and drives the core's control/ad_in/data_in interface through reset, length load, block load and start phases.
- Reads the digest back through ad_out/data_out and presents it as one wide word with a valid pulse.
- The core performs padding from the loaded length. This block supplies message bits only, zero-filled past msg_len.

Parameters:
- WIDTH, 32, core word width: 32 (SHA-224/256), 64 (SHA-384/512).
- MAX_H, 8, number of digest words read back: 7 for 224, 6 for 384, 4 for 512/t, else 8.
- BLOCK_SIZE, 16*WIDTH, bits per block.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- msg_start  in  1  one-cycle request; msg_len is sampled with it.
- msg_len  in  2*WIDTH  message length in bits.
- busy  out  1  high from accepted msg_start until dig_valid.
- in_data  in  WIDTH  message word, MSB-first, left-aligned.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block accepts in_data this cycle.
- core_control  out  4  0001 reset, 1000 length, 0010 load, 0100 start, 0000 idle.
- core_ad_in  out  5  core write address.
- core_data_in  out  WIDTH  core write data.
- core_ad_out  out  5  core read address.
- core_data_out  in  WIDTH  core read data.
- core_end_op  in  1  core block-done flag.
- dig_out  out  MAX_H*WIDTH  digest; word 0 in the MS bits.
- dig_valid  out  1  one-cycle pulse, dig_out stable until next msg_start.

Behaviour:
- Reset (async, any state) clears all of the following to zero and returns to IDLE:
  - core_control, core_ad_in, core_data_in, core_ad_out
  - in_ready, busy, dig_valid, dig_out
  - all counters
- Latched at msg_start:
  - len = msg_len
  - n_words = ceil(len/WIDTH), count of input words to consume
  - n_block = ((len + 2*WIDTH) / BLOCK_SIZE) + 1, computed with 2*WIDTH+1-bit arithmetic and no overflow
  - rem = len mod WIDTH
- IDLE: control 0000. On msg_start, go to CRST and set busy=1. msg_start in any other state is ignored.
- CRST: control 0001 for 2 cycles, then go to LEN.
- LEN: control 1000.
  - Cycle 1: ad_in=0. Cycle 2: data_in=len[2W-1:W].
  - Cycle 3: ad_in=1. Cycle 4: data_in=len[W-1:0].
  - Cycle 5: hold. Then go to LOAD with blk=0, widx=0.
- LOAD: control 0010. Each word takes two phases.
  - ADDR phase: ad_in=widx.
    - If input words remain, in_ready=1 and the phase stays put until in_valid.
    - On transfer the word is registered.
    - If this is the last input word and rem≠0, bits below the top rem bits are zeroed.
    - If no input words remain, in_ready=0, the word is 0 and the block advances without stalling.
  - DATA phase: data_in=word for one cycle.
  - After widx=15, go to START.
  - in_ready is never high outside a LOAD ADDR phase.
- START: control 0100, held until core_end_op is sampled high.
  - Then blk++. If blk<n_block, go to LOAD (widx=0); else go to READ (i=0).
  - core_end_op is ignored outside START.
- READ: ad_out=i for one cycle; next cycle capture core_data_out into dig_out word i.
  - After i=MAX_H-1, go to DONE.
- DONE: dig_valid=1 for 1 cycle, busy=0, control 0000, return to IDLE.
- Extra input words beyond n_words are not consumed (in_ready stays 0).
- Ad_in and data_in hold their last values between phases.
- len=0: n_words=0, one all-zero block, no input consumed.
- Reset asserted mid-LOAD or mid-START: the core is left as-is. The next message begins with CRST, which restarts the core.

Test Plan:
- "abc": len=24, in_data=0x616263FF → one block, word0=0x61626300 (masked), words1..15=0 → dig_out=ba7816bf8f01cfa414…f20015ad; exactly 1 word consumed.
- Empty message: len=0 → no in_ready, 1 block → dig_out=e3b0c44298fc1c14…7852b855.
- len=448: abcdbcdecdefdefg…nopq, 14 words → n_block=2, second block all zero → 248d6a61…19db06c1; len=447 → n_block=1.
- Stalls: the abc… 448-bit case with in_valid low for 5 cycles on word 7 → core_ad_in held at 7 and control held at 0010 during the stall; same digest; cycle count +5.
- rst pulsed during block 1 LOAD → all outputs 0 immediately, IDLE; the following "abc" message yields the correct digest.
- msg_start pulsed while busy with a different msg_len → ignored; busy stays high; the digest is that of the original message.
